// File: rtl/sva_window_checker.sv
// sva_window_checker: per-channel trigger->response latency window checker with
// saturating pass/fail counters. Define SVA_CHECK_MSG_EN for simulation-only messages.
module sva_window_checker #(
  parameter int  NUM_CH  = 4,
  parameter int  MIN_LAT = 2,
  parameter int  MAX_LAT = 5,
  parameter int  CNT_W   = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] resp,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] fail_pulse,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [NUM_CH-1:0] err_sticky,
  output logic [CH_W-1:0]   last_fail_ch,
  output logic [1:0]        last_fail_code
);
  localparam int TMR_W = 8;
  localparam int EV_W  = $clog2(2 * NUM_CH + 1);
  localparam logic [TMR_W-1:0] MIN_K = TMR_W'(MIN_LAT);
  localparam logic [TMR_W-1:0] MAX_K = TMR_W'(MAX_LAT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
  typedef enum logic [1:0] {
    C_NONE    = 2'b00,
    C_EARLY   = 2'b01,
    C_TIMEOUT = 2'b10,
    C_OVERLAP = 2'b11
  } code_e;

  state_e            state_q  [NUM_CH];
  state_e            state_d  [NUM_CH];
  logic [TMR_W-1:0]  timer_q  [NUM_CH];
  logic [TMR_W-1:0]  timer_d  [NUM_CH];
  code_e             win_code [NUM_CH];
  logic [NUM_CH-1:0] pass_ev, win_fail, ovl_fail, win_close, fail_vec;
  logic [EV_W-1:0]   pass_n, fail_n;
  logic              fail_any;
  logic [CH_W-1:0]   first_ch;
  code_e             first_code;

  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [NUM_CH-1:0] fail_pulse_q;
  logic [NUM_CH-1:0] err_sticky_q, err_sticky_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;
  code_e             last_code_q, last_code_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [EV_W-1:0]  b);
    logic [CNT_W+EV_W-1:0] s;
    s = {{EV_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    if (s > {{EV_W{1'b0}}, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // Per-channel window FSM. k lives in timer_q and runs 1..MAX_LAT while in WAIT.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d[ch]   = state_q[ch];
      timer_d[ch]   = timer_q[ch];
      win_code[ch]  = C_NONE;
      pass_ev[ch]   = 1'b0;
      win_fail[ch]  = 1'b0;
      ovl_fail[ch]  = 1'b0;
      win_close[ch] = 1'b0;
      if (state_q[ch] == S_IDLE) begin
        if (trig[ch]) begin
          state_d[ch] = S_WAIT;
          timer_d[ch] = TMR_W'(1);
        end
      end else begin
        win_close[ch] = resp[ch] || (timer_q[ch] == MAX_K);
        if (resp[ch]) begin
          if (timer_q[ch] < MIN_K) begin
            win_fail[ch] = 1'b1;
            win_code[ch] = C_EARLY;
          end else begin
            pass_ev[ch] = 1'b1;
          end
        end else if (timer_q[ch] == MAX_K) begin
          win_fail[ch] = 1'b1;
          win_code[ch] = C_TIMEOUT;
        end
        if (win_close[ch]) begin
          if (trig[ch]) begin
            timer_d[ch] = TMR_W'(1);
          end else begin
            state_d[ch] = S_IDLE;
            timer_d[ch] = '0;
          end
        end else begin
          timer_d[ch]  = timer_q[ch] + TMR_W'(1);
          ovl_fail[ch] = trig[ch];
        end
      end
      if (!en || clr) begin
        state_d[ch]  = S_IDLE;
        timer_d[ch]  = '0;
        pass_ev[ch]  = 1'b0;
        win_fail[ch] = 1'b0;
        ovl_fail[ch] = 1'b0;
      end
    end
  end

  assign fail_vec = win_fail | ovl_fail;

  // Walk downward so the lowest failing channel wins the record.
  always_comb begin
    fail_any   = 1'b0;
    first_ch   = '0;
    first_code = C_NONE;
    pass_n     = '0;
    fail_n     = '0;
    for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
      pass_n = pass_n + EV_W'(pass_ev[ch]);
      fail_n = fail_n + EV_W'(win_fail[ch]) + EV_W'(ovl_fail[ch]);
      if (fail_vec[ch]) begin
        fail_any   = 1'b1;
        first_ch   = CH_W'(ch);
        first_code = win_fail[ch] ? win_code[ch] : C_OVERLAP;
      end
    end
    pass_cnt_d   = sat_add(pass_cnt_q, pass_n);
    fail_cnt_d   = sat_add(fail_cnt_q, fail_n);
    err_sticky_d = err_sticky_q | fail_vec;
    last_ch_d    = fail_any ? first_ch : last_ch_q;
    last_code_d  = fail_any ? first_code : last_code_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      // NOTE: the per-channel state arrays are a handful of flops, so reset them like any register.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= S_IDLE;
        timer_q[ch] <= '0;
      end
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      fail_pulse_q <= '0;
      err_sticky_q <= '0;
      last_ch_q    <= '0;
      last_code_q  <= C_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        timer_q[ch] <= timer_d[ch];
      end
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_pulse_q <= fail_vec;
      err_sticky_q <= err_sticky_d;
      last_ch_q    <= last_ch_d;
      last_code_q  <= last_code_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int ch = 0; ch < NUM_CH; ch++) busy[ch] = (state_q[ch] == S_WAIT);
  end

  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign fail_pulse     = fail_pulse_q;
  assign err_sticky     = err_sticky_q;
  assign last_fail_ch   = last_ch_q;
  assign last_fail_code = last_code_q;

`ifdef SVA_CHECK_MSG_EN
`ifndef SYNTHESIS
  // Messages fire on the same edge that registers the result.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (pass_ev[ch])  $display("PASS ch%0d lat%0d", ch, timer_q[ch]);
        if (win_fail[ch]) $error("FAIL ch%0d code%0b", ch, 2'(win_code[ch]));
        if (ovl_fail[ch]) $error("FAIL ch%0d code%0b", ch, 2'(C_OVERLAP));
      end
    end
  end
`endif
`else
  // Messages disabled: state and outputs are identical to the message build.
`endif

endmodule

// File: tb/tb_sva_window_checker.sv
// Self-checking bench for sva_window_checker: hand-written vectors, corner sequences,
// and random traffic against a timestamp-based reference model.
module tb_sva_window_checker;
  localparam int NUM_CH  = 4;
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 5;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n, en, clr;
  logic [NUM_CH-1:0] trig, resp;
  logic [NUM_CH-1:0] busy, fail_pulse, err_sticky;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;
  logic [1:0]        last_fail_ch, last_fail_code;

  always #5 clk = ~clk;

  sva_window_checker #(
    .NUM_CH(NUM_CH), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .resp(resp),
    .busy(busy), .fail_pulse(fail_pulse), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_sticky(err_sticky), .last_fail_ch(last_fail_ch), .last_fail_code(last_fail_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each open window remembers the cycle its trigger was sampled.
  bit              m_open  [NUM_CH];
  int              m_start [NUM_CH];
  int              m_cyc = 0;
  int              m_pass, m_fail;
  logic [NUM_CH-1:0] m_pulse, m_sticky;
  logic [1:0]      m_last_ch, m_code;

  task automatic model_step(input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] r,
                            input logic e, input logic c, input logic rn);
    int  nf, code, lat;
    bit  still, found;
    m_cyc++;
    if (!rn || c) begin
      for (int ch = 0; ch < NUM_CH; ch++) m_open[ch] = 1'b0;
      m_pass = 0; m_fail = 0; m_pulse = '0; m_sticky = '0; m_last_ch = '0; m_code = '0;
      return;
    end
    m_pulse = '0;
    if (!e) begin
      for (int ch = 0; ch < NUM_CH; ch++) m_open[ch] = 1'b0;
      return;
    end
    found = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      nf = 0; code = 0; still = m_open[ch];
      if (m_open[ch]) begin
        lat = m_cyc - m_start[ch];
        if (r[ch]) begin
          still = 1'b0;
          if (lat < MIN_LAT) begin nf++; code = 1; end
          else m_pass = (m_pass < CNT_MAX) ? m_pass + 1 : CNT_MAX;
        end else if (lat == MAX_LAT) begin
          still = 1'b0; nf++; code = 2;
        end
        if (still && t[ch]) begin nf++; if (code == 0) code = 3; end
      end
      if (t[ch] && !still) begin still = 1'b1; m_start[ch] = m_cyc; end
      m_open[ch] = still;
      if (nf > 0) begin
        m_fail = (m_fail + nf > CNT_MAX) ? CNT_MAX : m_fail + nf;
        m_pulse[ch]  = 1'b1;
        m_sticky[ch] = 1'b1;
        if (!found) begin found = 1'b1; m_last_ch = 2'(ch); m_code = 2'(code); end
      end
    end
  endtask

  task automatic check_model();
    logic [NUM_CH-1:0] mb;
    for (int ch = 0; ch < NUM_CH; ch++) mb[ch] = m_open[ch];
    check("busy", busy, mb);
    check("fail_pulse", fail_pulse, m_pulse);
    check("pass_cnt", pass_cnt, m_pass);
    check("fail_cnt", fail_cnt, m_fail);
    check("err_sticky", err_sticky, m_sticky);
    check("last_fail_ch", last_fail_ch, m_last_ch);
    check("last_fail_code", last_fail_code, m_code);
  endtask

  // Drive at the falling edge, let the rising edge register, sample at the next falling edge.
  task automatic step(input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] r,
                      input logic e, input logic c, input logic rn, input bit do_chk);
    trig = t; resp = r; en = e; clr = c; rst_n = rn;
    @(posedge clk);
    model_step(t, r, e, c, rn);
    @(negedge clk);
    if (do_chk) check_model();
  endtask

  typedef struct {
    logic [NUM_CH-1:0] trig, resp, busy, pulse, sticky;
    int                pass_c, fail_c;
    logic [1:0]        last_ch, code;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [NUM_CH-1:0] t, r;
    logic              e, c, rn;

    // trig, resp | busy, pulse, sticky, pass, fail, last_ch, code (values after the edge)
    vecs.push_back('{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 2'd0, 2'd0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 2'd0, 2'd0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 2'd0, 2'd0});
    vecs.push_back('{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0});
    vecs.push_back('{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0});
    vecs.push_back('{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1, 1, 2'd1, 2'd1});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, 1, 2'd1, 2'd1});
    vecs.push_back('{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 1, 1, 2'd1, 2'd1});
    vecs.push_back('{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 1, 1, 2'd1, 2'd1});
    vecs.push_back('{4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1010, 1, 2, 2'd3, 2'd3});
    vecs.push_back('{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1010, 1, 2, 2'd3, 2'd3});
    vecs.push_back('{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1010, 2, 2, 2'd3, 2'd3});
    vecs.push_back('{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b1010, 2, 2, 2'd3, 2'd3});
    vecs.push_back('{4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b1011, 2, 4, 2'd0, 2'd1});
    vecs.push_back('{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1011, 2, 4, 2'd0, 2'd1});
    vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 2, 5, 2'd2, 2'd1});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 2, 5, 2'd2, 2'd1});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 2, 5, 2'd2, 2'd1});
    vecs.push_back('{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 3, 5, 2'd2, 2'd1});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 3, 5, 2'd2, 2'd1});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 3, 5, 2'd2, 2'd1});
    vecs.push_back('{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4, 5, 2'd2, 2'd1});

    trig = '0; resp = '0; en = 1'b1; clr = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset busy", busy, 0);
    check("reset pass_cnt", pass_cnt, 0);
    check("reset fail_cnt", fail_cnt, 0);
    check("reset sticky", err_sticky, 0);
    check("reset code", last_fail_code, 0);

    // Hand-derived vectors: pass at k=3, early, overlap + pass, dual early, IDLE resp, k=MIN and k=MAX passes.
    foreach (vecs[i]) begin
      step(vecs[i].trig, vecs[i].resp, 1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d fail_pulse", i), fail_pulse, vecs[i].pulse);
      check($sformatf("vec%0d sticky", i), err_sticky, vecs[i].sticky);
      check($sformatf("vec%0d pass_cnt", i), pass_cnt, vecs[i].pass_c);
      check($sformatf("vec%0d fail_cnt", i), fail_cnt, vecs[i].fail_c);
      check($sformatf("vec%0d last_ch", i), last_fail_ch, vecs[i].last_ch);
      check($sformatf("vec%0d code", i), last_fail_code, vecs[i].code);
    end

    // Timeout at k=MAX_LAT with a back-to-back trigger, then a plain timeout.
    step(4'b0100, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < MAX_LAT - 1; i++) step('0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(4'b0100, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t3 pulse", fail_pulse, 4'b0100);
    check("t3 code", last_fail_code, 2'b10);
    check("t3 busy kept", busy, 4'b0100);
    check("t3 fail_cnt", fail_cnt, 6);
    for (int i = 0; i < MAX_LAT; i++) step('0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t3 second timeout", fail_cnt, 7);
    check("t3 idle", busy, 4'b0000);

    // Reset in the middle of a window.
    step(4'b0010, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6 rst busy", busy, 0);
    check("t6 rst fail_cnt", fail_cnt, 0);
    check("t6 rst pass_cnt", pass_cnt, 0);
    check("t6 rst sticky", err_sticky, 0);

    // en=0 abandons the window; a response afterwards lands in IDLE and is ignored.
    step(4'b0001, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step('0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t6 en0 busy", busy, 0);
    check("t6 en0 pass_cnt", pass_cnt, 0);
    step('0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t6 stale resp pass_cnt", pass_cnt, 0);
    check("t6 stale resp fail_cnt", fail_cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      t  = 4'($urandom) & 4'($urandom);
      r  = 4'($urandom) & 4'($urandom);
      e  = ($urandom_range(31) != 0);
      c  = ($urandom_range(199) == 0);
      rn = ($urandom_range(499) != 0);
      step(t, r, e, c, rn, 1'b1);
    end

    // Saturation: drive fail_cnt up to 16'hFFFE, then two more failures.
    step('0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20000 && m_fail < CNT_MAX - 35; i++)
      step(4'b1111, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MAX_LAT + 2; i++) step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100 && m_fail < CNT_MAX - 1; i++)
      step(4'b0001, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_model();
    check("t5 near max", fail_cnt, 16'hFFFE);
    step(4'b0001, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t5 reach max", fail_cnt, 16'hFFFF);
    step(4'b0001, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t5 hold max", fail_cnt, 16'hFFFF);
    check("t5 pulse at max", fail_pulse, 4'b0001);

    step(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr fail_cnt", fail_cnt, 0);
    check("clr pass_cnt", pass_cnt, 0);
    check("clr sticky", err_sticky, 0);
    check("clr last_ch", last_fail_ch, 0);
    check("clr code", last_fail_code, 0);
    check("clr busy", busy, 0);
    check("clr pulse", fail_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
